imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL provide parameter: HOLD_CYCLES, default 4, number of cycles cpu_rst stays low after a successful load before release.
REQ-002 SHALL provide port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port: rst  input  1  synchronous, active-low reset.
REQ-004 SHALL provide port: start  input  1  begin load; sampled only in IDLE, DONE, ERR.
REQ-005 SHALL provide port: in_valid  input  1  byte-stream source has a valid byte.
REQ-006 SHALL provide port: in_data  input  8  byte-stream data.
REQ-007 SHALL provide port: in_ready  output  1  loader accepts in_data this cycle.
REQ-008 SHALL provide port: im_wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL provide port: im_addr  output  8  instruction-memory word address.
REQ-010 SHALL provide port: im_wr_data  output  16  instruction word to write.
REQ-011 SHALL provide port: cpu_rst  output  1  active-low reset driven to the processor core; low holds the core in reset.
REQ-012 SHALL provide port: busy  output  1  high in every state except IDLE, DONE, ERR.
REQ-013 SHALL provide port: done  output  1  high in DONE.
REQ-014 SHALL provide port: err  output  1  high in ERR.

Function
REQ-015 SHALL accept a byte only on a cycle where in_valid and in_ready are both high; no byte is consumed otherwise.
REQ-016 SHALL implement states IDLE, LEN, HI, LO, WRITE, CSUM, HOLD, DONE, ERR.
REQ-017 SHALL move IDLE/DONE/ERR -> LEN on start=1, clearing im_addr, word count, checksum accumulator, done and err, and driving cpu_rst low from the next cycle.
REQ-018 SHALL in LEN take the accepted byte as word count N, with 0 meaning 256, then go to HI.
REQ-019 SHALL in HI store the accepted byte as im_wr_data[15:8], then go to LO.
REQ-020 SHALL in LO store the accepted byte as im_wr_data[7:0], then go to WRITE.
REQ-021 SHALL in WRITE assert im_wr_en for exactly one cycle with in_ready low, then increment im_addr modulo 256 and go to HI if words remain, else to CSUM.
REQ-022 SHALL keep the checksum as the 8-bit XOR of every HI and LO data byte, excluding the length byte.
REQ-023 SHALL in CSUM compare the accepted byte against the checksum: equal -> HOLD, unequal -> ERR.
REQ-024 SHALL in HOLD keep cpu_rst low for HOLD_CYCLES cycles, then go to DONE and drive cpu_rst high.
REQ-025 SHALL drive in_ready high only in LEN, HI, LO, CSUM, combinationally from state.
REQ-026 SHALL keep cpu_rst low in IDLE, LEN, HI, LO, WRITE, CSUM, HOLD, ERR, and high only in DONE.
REQ-027 SHALL ignore start outside IDLE, DONE, ERR; a load in progress is never restarted by start.
REQ-028 SHALL write all 256 words with im_addr 0..255 when N=0, leaving im_addr wrapped to 0 afterwards.
REQ-029 SHALL tolerate in_valid stalls of any length in LEN/HI/LO/CSUM with all state and outputs held.
REQ-030 SHALL hold im_addr and im_wr_data stable in the cycle im_wr_en is high.

Reset
REQ-031 SHALL on rst=0 at a rising edge enter IDLE with cpu_rst=0, in_ready=0, im_wr_en=0, im_addr=0, im_wr_data=0, busy=0, done=0, err=0, checksum and word count 0.
REQ-032 SHALL abandon a load in progress on reset mid-transfer with no further im_wr_en pulse, and have no effect on the following cycle's outputs other than the values in REQ-031.

Verification
REQ-033 SHALL pass: start; bytes 02,12,34,AB,CD,checksum 40 -> writes 1234@00 and ABCD@01, one im_wr_en each, cpu_rst rises 4 cycles after checksum accept, done=1.
REQ-034 SHALL pass: same stream with checksum 41 -> both words written, state ERR, err=1, cpu_rst stays 0; a new start then clears err.
REQ-035 SHALL pass: N=00 then 512 data bytes plus correct XOR -> 256 writes at addresses 00..FF, done=1, im_addr=00.
REQ-036 SHALL pass: random in_valid gaps of 0-5 cycles during the REQ-033 stream -> identical writes, no duplicated or dropped bytes.
REQ-037 SHALL pass: rst=0 asserted after the HI byte of word 1 -> next cycle IDLE, no im_wr_en, all outputs at REQ-031 values.
REQ-038 SHALL pass: start pulsed during LO -> ignored; load completes as in REQ-033.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length-prefixed, XOR-checksummed
// byte stream, writes 16-bit words into instruction memory and releases the core's reset.
module imem_loader #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_wr_en,
    output logic [7:0]  im_addr,
    output logic [15:0] im_wr_data,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  dbg_state
);

    // Handshake: a byte moves only on a rising edge where in_valid && in_ready;
    // in_ready depends on state alone, so the source may react to it combinationally.

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_LEN   = 4'd1;
    localparam logic [3:0] S_HI    = 4'd2;
    localparam logic [3:0] S_LO    = 4'd3;
    localparam logic [3:0] S_WRITE = 4'd4;
    localparam logic [3:0] S_CSUM  = 4'd5;
    localparam logic [3:0] S_HOLD  = 4'd6;
    localparam logic [3:0] S_DONE  = 4'd7;
    localparam logic [3:0] S_ERR   = 4'd8;

    // HOLD always lasts at least one cycle, even with HOLD_CYCLES of zero.
    localparam logic [15:0] HOLD_LAST = (HOLD_CYCLES > 1) ? 16'(HOLD_CYCLES - 1) : 16'd0;

    logic [3:0]  state;
    logic [8:0]  words_left;
    logic [7:0]  csum;
    logic [15:0] hold_cnt;
    logic        accept;

    assign in_ready  = (state == S_LEN) || (state == S_HI) ||
                       (state == S_LO)  || (state == S_CSUM);
    assign accept    = in_valid && in_ready;
    assign im_wr_en  = (state == S_WRITE);
    assign cpu_rst   = (state == S_DONE);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);
    assign busy      = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            words_left <= 9'd0;
            csum       <= 8'd0;
            hold_cnt   <= 16'd0;
            im_addr    <= 8'd0;
            im_wr_data <= 16'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_LEN;
                        im_addr    <= 8'd0;
                        words_left <= 9'd0;
                        csum       <= 8'd0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        // A length byte of zero stands for a full 256-word image.
                        words_left <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                        state      <= S_HI;
                    end
                end
                S_HI: begin
                    if (accept) begin
                        im_wr_data[15:8] <= in_data;
                        csum             <= csum ^ in_data;
                        state            <= S_LO;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        im_wr_data[7:0] <= in_data;
                        csum            <= csum ^ in_data;
                        state           <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    im_addr    <= im_addr + 8'd1;
                    words_left <= words_left - 9'd1;
                    state      <= (words_left == 9'd1) ? S_CSUM : S_HI;
                end
                S_CSUM: begin
                    if (accept) begin
                        hold_cnt <= 16'd0;
                        state    <= (in_data == csum) ? S_HOLD : S_ERR;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= S_DONE;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random word images and stalls, scored against a
// word-list reference model of the expected memory writes and load outcome.
module tb_imem_loader;

    localparam int HOLD = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_wr_en;
    logic [7:0]  im_addr;
    logic [15:0] im_wr_data;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] word_mem [256];
    logic [23:0] exp_q [$];
    logic [23:0] act_q [$];
    int          ready_viol = 0;

    imem_loader #(.HOLD_CYCLES(HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .im_wr_en   (im_wr_en),
        .im_addr    (im_addr),
        .im_wr_data (im_wr_data),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (im_wr_en) begin
            act_q.push_back({im_addr, im_wr_data});
            if (in_ready) ready_viol++;
        end
    end

    // Driver: present one byte after a random gap and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int budget;
        gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        budget   = 0;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte_timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Full load of word_mem[0..nw-1]; the model derives writes and checksum from the word list.
    task automatic do_load(input string name, input int nw, input int gap,
                           input bit bad, input bit poke);
        logic [7:0] cs;
        int         n;
        cs = 8'd0;
        exp_q.delete();
        act_q.delete();
        ready_viol = 0;
        for (int i = 0; i < nw; i++) begin
            exp_q.push_back({8'(i % 256), word_mem[i]});
            cs = cs ^ word_mem[i][15:8] ^ word_mem[i][7:0];
        end
        pulse_start();
        n_checks++;
        if (busy !== 1'b1 || cpu_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_start: busy=%b cpu_rst=%b, required busy=1 cpu_rst=0", name, busy, cpu_rst);
        end
        send_byte(8'(nw % 256), gap);
        for (int i = 0; i < nw; i++) begin
            send_byte(word_mem[i][15:8], gap);
            if (poke && i == 0) pulse_start();
            send_byte(word_mem[i][7:0], gap);
        end
        send_byte(bad ? (cs ^ 8'h01) : cs, gap);
        if (!bad) begin
            n = 0;
            while (cpu_rst !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            n_checks++;
            if (n != HOLD) begin
                n_fail++;
                $display("FAIL %s_hold: cpu_rst rose after %0d cycles, required %0d", name, n, HOLD);
            end
            n_checks++;
            if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_done: done=%b err=%b busy=%b, required 1 0 0", name, done, err, busy);
            end
        end else begin
            n = 0;
            repeat (10) begin
                if (cpu_rst !== 1'b0) n++;
                @(negedge clk);
            end
            n_checks++;
            if (n != 0 || err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_err: cpu_rst high %0d cycles, err=%b done=%b busy=%b, required 0 1 0 0",
                         name, n, err, done, busy);
            end
        end
        n_checks++;
        if (act_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_write_count: got %0d writes, required %0d", name, act_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (act_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL %s_write[%0d]: got addr/data %h, required %h", name, i, act_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (ready_viol != 0 || im_addr !== 8'(nw % 256)) begin
            n_fail++;
            $display("FAIL %s_addr: im_addr=%h ready_during_write=%0d, required %h and 0",
                     name, im_addr, ready_viol, 8'(nw % 256));
        end
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if ({cpu_rst, in_ready, im_wr_en, busy, done, err} !== 6'b0 ||
            im_addr !== 8'h00 || im_wr_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL %s: cpu_rst=%b in_ready=%b wr_en=%b busy=%b done=%b err=%b addr=%h data=%h, required all 0",
                     name, cpu_rst, in_ready, im_wr_en, busy, done, err, im_addr, im_wr_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_state");
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_directed_ok();
        word_mem[0] = 16'h1234;
        word_mem[1] = 16'hABCD;
        do_load("directed_ok", 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_bad_csum();
        word_mem[0] = 16'h1234;
        word_mem[1] = 16'hABCD;
        do_load("bad_csum", 2, 0, 1'b1, 1'b0);
        pulse_start();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1 || cpu_rst !== 1'b0 || im_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL restart_after_err: err=%b busy=%b cpu_rst=%b addr=%h, required 0 1 0 00",
                     err, busy, cpu_rst, im_addr);
        end
        do_reset();
    endtask

    task automatic test_full_256();
        for (int i = 0; i < 256; i++) word_mem[i] = 16'($urandom);
        do_load("full_256", 256, 0, 1'b0, 1'b0);
    endtask

    task automatic test_gaps();
        word_mem[0] = 16'h1234;
        word_mem[1] = 16'hABCD;
        do_load("gaps", 2, 5, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        act_q.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h34;
        @(negedge clk);
        check_reset_values("reset_mid_next_cycle");
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (act_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_write: got %0d writes busy=%b, required 0 writes busy=0",
                     act_q.size(), busy);
        end
    endtask

    task automatic test_start_in_lo();
        word_mem[0] = 16'h1234;
        word_mem[1] = 16'hABCD;
        do_load("start_in_lo", 2, 0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int nw;
        for (int k = 0; k < 6; k++) begin
            nw = $urandom_range(1, 20);
            for (int i = 0; i < nw; i++) word_mem[i] = 16'($urandom);
            do_load("random", nw, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_directed_ok();
        test_bad_csum();
        test_full_256();
        test_gaps();
        test_reset_mid();
        test_start_in_lo();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
